cmp_bist: RTL

Self-checking stimulus engine for the combinational `comparator` block. It drives the comparator's `A`/`B` inputs from an on-chip LFSR and samples the `aequalsb`/`agreaterb`/`alesserb` flags. It checks each result against an internal reference and reports pass/fail plus an error count. It sits beside a `comparator` instance as its driver/monitor, replacing random stimulus with a synthesizable, repeatable built-in self-test.

---
 rtl/cmp_bist_pkg.sv | 70 +++++++
 rtl/cmp_bist_lfsr.sv | 47 ++++
 rtl/cmp_bist.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cmp_bist_pkg.sv
// -----------------------------------------------------------------------------
// cmp_bist_pkg
// Shared definitions for the comparator built-in self-test:
//   - state_t    : FSM state encoding (IDLE, DRIVE, CHECK, DONE)
//   - lfsr_taps  : maximal-length Fibonacci tap masks for widths 4..32
//   - cmp_ref    : reference comparison returning {eq,gt,lt}
// -----------------------------------------------------------------------------
package cmp_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LFSR_W_MIN = 4;
    localparam int LFSR_W_MAX = 32;

    // Mask with a single bit set for polynomial term x^n (bit n-1).
    function automatic logic [31:0] tap(input int n);
        return 32'h1 << (n - 1);
    endfunction

    // Tap mask for a W-bit maximal-length LFSR; feedback is the XOR of the
    // masked state bits. Unsupported widths return 0.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] m;
        m = '0;
        case (w)
            4:  m = tap(4)  | tap(3);
            5:  m = tap(5)  | tap(3);
            6:  m = tap(6)  | tap(5);
            7:  m = tap(7)  | tap(6);
            8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:  m = tap(9)  | tap(5);
            10: m = tap(10) | tap(7);
            11: m = tap(11) | tap(9);
            12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
            13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
            14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
            15: m = tap(15) | tap(14);
            16: m = tap(16) | tap(15) | tap(13) | tap(4);
            17: m = tap(17) | tap(14);
            18: m = tap(18) | tap(11);
            19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
            20: m = tap(20) | tap(17);
            21: m = tap(21) | tap(19);
            22: m = tap(22) | tap(21);
            23: m = tap(23) | tap(18);
            24: m = tap(24) | tap(23) | tap(22) | tap(17);
            25: m = tap(25) | tap(22);
            26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
            27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
            28: m = tap(28) | tap(25);
            29: m = tap(29) | tap(27);
            30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
            31: m = tap(31) | tap(28);
            32: m = tap(32) | tap(22) | tap(2)  | tap(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    // Unsigned reference compare; callers zero-extend operands to 16 bits.
    function automatic logic [2:0] cmp_ref(input logic [15:0] a, input logic [15:0] b);
        return {a == b, a > b, a < b};
    endfunction

endpackage

// File: rtl/cmp_bist_lfsr.sv
// -----------------------------------------------------------------------------
// cmp_bist_lfsr
// Fibonacci left-shift LFSR used as the vector source.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   synchronous active-low reset (state cleared to 0)
//   load  in   load SEED (0 is replaced by 1)
//   step  in   advance one position: {state[W-2:0], feedback}
//   state out  current LFSR contents (registered)
// -----------------------------------------------------------------------------
module cmp_bist_lfsr
    import cmp_bist_pkg::*;
#(
    parameter int           W    = 10,
    parameter logic [W-1:0] SEED = {{(W-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS     = W'(lfsr_taps(W));
    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;

    logic [W-1:0] r_state;
    logic         w_fb;

    assign w_fb = ^(r_state & TAPS);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= SEED_EFF;
        end else if (step) begin
            r_state <= {r_state[W-2:0], w_fb};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/cmp_bist.sv
// -----------------------------------------------------------------------------
// cmp_bist
// Built-in self-test driver/monitor for a combinational comparator. Operands
// come from an LFSR; returned flags are checked against a reference compare.
// Optional feature macro: CMP_BIST_FAIL_LOG_EN (captures first failing vector;
// when undefined, fail_* are tied to 0).
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   start                         run request, sampled only in IDLE
//   A, B                          operands to the comparator (registered)
//   aequalsb/agreaterb/alesserb   comparator flags
//   busy, done, pass              run status (done is a one-cycle pulse)
//   err_count, vec_idx            failing-vector count, current vector index
//   fail_a, fail_b, fail_flags    first failing vector, flags as {eq,gt,lt}
// -----------------------------------------------------------------------------
module cmp_bist
    import cmp_bist_pkg::*;
#(
    parameter int                SIZE        = 5,
    parameter int                NUM_VECTORS = 10,
    parameter logic [2*SIZE-1:0] SEED        = {{(2*SIZE-1){1'b0}}, 1'b1}
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic [SIZE-1:0]                    A,
    output logic [SIZE-1:0]                    B,
    input  logic                               aequalsb,
    input  logic                               agreaterb,
    input  logic                               alesserb,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   err_count,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_idx,
    output logic [SIZE-1:0]                    fail_a,
    output logic [SIZE-1:0]                    fail_b,
    output logic [2:0]                         fail_flags
);

    localparam int           W        = 2 * SIZE;
    localparam int           CW       = $clog2(NUM_VECTORS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VECTORS - 1);

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [CW-1:0] r_err_count;
    logic [CW-1:0] r_vec_idx;

    logic          w_load;
    logic          w_step;
    logic [W-1:0]  w_lfsr;
    logic [2:0]    w_flags;
    logic [2:0]    w_ref;
    logic          w_fail;
    logic [CW-1:0] w_err_next;

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_step = (r_state == ST_CHECK) && (r_vec_idx < LAST_IDX);

    cmp_bist_lfsr #(
        .W    (W),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .state (w_lfsr)
    );

    // Operands are the LFSR register halves, so they are registered and
    // change exactly when the LFSR is loaded or stepped.
    assign A = w_lfsr[W-1:SIZE];
    assign B = w_lfsr[SIZE-1:0];

    // Any bit differing from the reference fails, which also catches
    // all-zero and multi-hot flag patterns.
    assign w_flags    = {aequalsb, agreaterb, alesserb};
    assign w_ref      = cmp_ref(16'(A), 16'(B));
    assign w_fail     = (r_state == ST_CHECK) && (w_flags != w_ref);
    assign w_err_next = r_err_count + CW'(w_fail);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_vec_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_DRIVE;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_count <= '0;
                        r_vec_idx   <= '0;
                    end
                end
                ST_DRIVE: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_err_count <= w_err_next;
                    if (r_vec_idx < LAST_IDX) begin
                        r_state   <= ST_DRIVE;
                        r_vec_idx <= r_vec_idx + CW'(1);
                    end else begin
                        // Pass must include the verdict of this final check.
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign vec_idx   = r_vec_idx;

`ifdef CMP_BIST_FAIL_LOG_EN
    logic [SIZE-1:0] r_fail_a;
    logic [SIZE-1:0] r_fail_b;
    logic [2:0]      r_fail_flags;

    // A zero error count before this check identifies the first failure.
    always_ff @(posedge clk) begin
        if (!rst_n || w_load) begin
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_flags <= '0;
        end else if (w_fail && (r_err_count == '0)) begin
            r_fail_a     <= A;
            r_fail_b     <= B;
            r_fail_flags <= w_flags;
        end
    end

    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;
    assign fail_flags = r_fail_flags;
`else
    assign fail_a     = '0;
    assign fail_b     = '0;
    assign fail_flags = '0;
`endif

endmodule
